// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the CONV layer memory slice.
package conv_pkg;

    localparam int DW        = 20;
    localparam int AW        = 12;
    localparam int IMG_DEPTH = 4096;
    localparam int L0_DEPTH  = 4096;
    localparam int L1_DEPTH  = 1024;
    localparam int L1_AW     = 10;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        WAIT_HI,
        WAIT_LO,
        DUMP,
        DONE
    } state_t;

endpackage

// File: rtl/conv_dump_stream.sv
// Dump read pointer with L0->L1 wrap and registered valid/ready output stage.
module conv_dump_stream
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] rd_data,
    output logic          rd_layer,
    output logic [AW-1:0] rd_addr,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_layer,
    output logic          last
);

    logic ptr_end;
    logic accept;
    logic load;
    logic l0_end;
    logic l1_end;

    assign accept = out_valid && out_ready;
    assign load   = en && !ptr_end && (!out_valid || out_ready);
    assign l0_end = !rd_layer && (rd_addr == AW'(L0_DEPTH - 1));
    assign l1_end = rd_layer && (rd_addr == AW'(L1_DEPTH - 1));
    assign last   = accept && out_layer
                  && (out_addr == AW'(L1_DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_layer  <= 1'b0;
            rd_addr   <= '0;
            ptr_end   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_layer <= 1'b0;
        end else if (clr) begin
            rd_layer  <= 1'b0;
            rd_addr   <= '0;
            ptr_end   <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_addr  <= rd_addr;
            out_layer <= rd_layer;
            if (l0_end) begin
                rd_layer <= 1'b1;
                rd_addr  <= '0;
            end else if (l1_end) begin
                // pointer parks here; only the final word remains in flight
                ptr_end <= 1'b1;
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_layer_mem.sv
// Image/L0/L1 banks for the CONV engine plus the run-launch and
// result-dump sequencer facing the host.
module conv_layer_mem
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          host_start,
    input  logic          img_we,
    input  logic [11:0]   img_addr,
    input  logic [19:0]   img_wdata,
    output logic          ready,
    input  logic          busy,
    input  logic [11:0]   iaddr,
    output logic [19:0]   idata,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [19:0]   cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [19:0]   cdata_rd,
    input  logic [2:0]    csel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [19:0]   out_data,
    output logic [11:0]   out_addr,
    output logic          out_layer,
    output logic          done
);

    logic [DW-1:0] img [IMG_DEPTH];
    logic [DW-1:0] l0  [L0_DEPTH];
    logic [DW-1:0] l1  [L1_DEPTH];

    state_t        state;
    state_t        state_nxt;
    logic          clr;
    logic          dump_en;
    logic          last;
    logic          rd_layer;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          img_open;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        clr       = 1'b0;
        dump_en   = 1'b0;
        unique case (state)
            IDLE:    if (host_start) state_nxt = KICK;
            KICK: begin
                ready     = 1'b1;
                state_nxt = WAIT_HI;
            end
            // busy may still read low right after the kick
            WAIT_HI: if (busy) state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!busy) begin
                    clr       = 1'b1;
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                dump_en = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (host_start) state_nxt = KICK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign img_open = (state == IDLE) || (state == DONE);

    always_ff @(posedge clk) begin
        if (img_we && img_open) img[img_addr] <= img_wdata;
    end

    always_ff @(posedge clk) begin
        if (cwr && (csel == CSEL_L0)) l0[caddr_wr] <= cdata_wr;
        if (cwr && (csel == CSEL_L1)) l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end

    assign idata = img[iaddr];

    always_comb begin
        cdata_rd = '0;
        if (crd && (csel == CSEL_L0))
            cdata_rd = l0[caddr_rd];
        else if (crd && (csel == CSEL_L1))
            cdata_rd = l1[caddr_rd[L1_AW-1:0]];
    end

    assign rd_data = rd_layer ? l1[rd_addr[L1_AW-1:0]] : l0[rd_addr];

    conv_dump_stream u_dump (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .en        (dump_en),
        .rd_data   (rd_data),
        .rd_layer  (rd_layer),
        .rd_addr   (rd_addr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_layer (out_layer),
        .last      (last)
    );

endmodule

// File: doc/conv_layer_mem.md
Name: conv_layer_mem

Overview:
- Memory-side responder and host sequencer for the CONV layer engine.
- Holds three banks:
  - image bank, 4096x20, read by the engine via iaddr/idata;
  - L0 bank, 4096x20;
  - L1 bank, 1024x20.
- Services the engine's cwr/crd/csel accesses.
- Pulses ready to launch a run, waits for busy to fall, then streams L0 and L1 results to the host over a valid/ready port.

Parameters:
- DW, 20, data width of all banks.
- AW, 12, engine address width.
- L0_DEPTH, 4096, L0 bank words.
- L1_DEPTH, 1024, L1 bank words.

Ports:
- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk
- reset  in  1  asynchronous active-high reset
- host_start  in  1  launch request, sampled in IDLE/DONE only
- img_we  in  1  host image write strobe
- img_addr  in  12  host image write address
- img_wdata  in  20  host image write data
- ready  out  1  run-launch pulse to engine
- busy  in  1  engine busy
- iaddr  in  12  engine image read address
- idata  out  20  image read data
- cwr  in  1  engine layer write strobe
- caddr_wr  in  12  layer write address
- cdata_wr  in  20  layer write data
- crd  in  1  engine layer read strobe
- caddr_rd  in  12  layer read address
- cdata_rd  out  20  layer read data
- csel  in  3  bank select: 3'b001 = L0, 3'b011 = L1
- out_valid  out  1  dump word valid
- out_ready  in  1  host accepts dump word
- out_data  out  20  dump word
- out_addr  out  12  dump word address within its bank
- out_layer  out  1  0 = L0, 1 = L1
- done  out  1  dump complete, level

Behaviour:
- Reset values:
  - ready = 0, out_valid = 0, out_data = 0, out_addr = 0, out_layer = 0, done = 0;
  - FSM = IDLE.
  - Bank contents are not reset.
- Engine read ports are combinational, zero latency:
  - idata = img[iaddr].
  - cdata_rd = L0[caddr_rd] when crd && csel == 001.
  - cdata_rd = L1[caddr_rd[9:0]] when crd && csel == 011.
  - cdata_rd = 0 otherwise.
- Engine writes are synchronous on posedge when cwr:
  - csel 001 → L0[caddr_wr];
  - csel 011 → L1[caddr_wr[9:0]];
  - any other csel → write dropped.
  - Writes are honoured in every state.
- Image writes:
  - img[img_addr] <= img_wdata on posedge when img_we, in IDLE or DONE only; ignored otherwise.
  - Same-cycle img_we and iaddr to the same address: idata returns the old word.
- FSM states: IDLE, KICK, WAIT_HI, WAIT_LO, DUMP, DONE.
  - IDLE: host_start → KICK.
  - KICK: ready = 1 for exactly one cycle → WAIT_HI.
  - WAIT_HI: busy = 1 → WAIT_LO. This guards against the stale busy = 0 immediately after KICK.
  - WAIT_LO: busy = 0 → DUMP. Clear the read pointer: layer = 0, addr = 0.
  - DUMP: stream L0 words 0..4095, then L1 words 0..1023. After L1 word 1023 is accepted → DONE.
  - DONE: done = 1. host_start → KICK with done cleared, so back-to-back runs are allowed.
- host_start in KICK, WAIT_HI, WAIT_LO or DUMP is ignored.
- Dump handshake:
  - out_data/out_addr/out_layer are registered.
  - Load the next word when !out_valid || (out_valid && out_ready).
  - While out_valid && !out_ready, all outputs hold stable.
  - First word is valid one cycle after entering DUMP.
  - Throughput is one word per cycle while out_ready = 1.
  - out_valid drops the cycle after the last word is accepted.
  - Pointer wrap: L0 addr 4095 accepted → layer = 1, addr = 0.
- Reset mid-operation: async return to IDLE, ready and out_valid deassert immediately, banks keep their contents.

Decomposition:
- Shared package conv_pkg:
  - CSEL_L0 = 3'b001, CSEL_L1 = 3'b011;
  - DW, AW, L0_DEPTH, L1_DEPTH;
  - FSM state enum.
- One natural sub-module, conv_dump_stream: read pointer, layer wrap, and valid/ready output register.
- Banks are inferred arrays in the top level.

Test Plan:
- Image load and engine read: load img[0x041] = 0x12345, start, drive iaddr = 0x041 → idata = 0x12345 in the same cycle.
- Launch handshake: host_start = 1 in IDLE → ready high for exactly one cycle. Hold busy = 0 for 3 cycles, then 1 for 10, then 0 → DUMP entered one cycle after busy falls, not earlier.
- Bank routing:
  - cwr, csel = 001, caddr_wr = 5, data 0x00ABC → crd, csel = 001, caddr_rd = 5 gives 0x00ABC.
  - csel = 011, caddr_rd = 5 gives the L1 value.
  - csel = 010 write → all banks unchanged, read returns 0.
- Dump streaming:
  - Preload L0[i] = i and L1[i] = 0x80000 + i.
  - out_ready = 1 → 5120 beats: beat 4095 = (layer 0, addr 4095, 4095), beat 4096 = (layer 1, addr 0, 0x80000); done rises after the last beat.
- Backpressure: toggle out_ready at random, 50% → no word dropped or duplicated, outputs stable while stalled.
- Reset mid-dump: assert reset at beat 100 → out_valid = 0 and FSM = IDLE. A new start with busy pulsed → dump restarts at L0 addr 0 with intact data.
